// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle between an initiator and a slave.
interface axil_master_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one command in, one AXI transaction out, one response back.
// Single transaction outstanding; every output is driven straight from a register.
module axil_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    axil_master_if.master         m_axil
);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            IDLE: begin
                // cmd_ready rises one edge after reset release, then stays up while idle
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    wstrb_d     = cmd_wstrb_i;
                    if (cmd_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid) begin
                    rsp_resp_d  = m_axil.bresp;
                    rsp_rdata_d = '0;
                    rsp_we_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil.rvalid) begin
                    rsp_resp_d  = m_axil.rresp;
                    rsp_rdata_d = m_axil.rdata;
                    rsp_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_we_o       = rsp_we_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_resp_o     = rsp_resp_q;

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = AXI_PROT;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = AXI_PROT;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

endmodule
